// File: rtl/tlc_pkg.sv
// Shared phase encodings, lamp codes and 50 MHz timing constants for the
// highway/farm-road phase scheduler.
package tlc_pkg;

    localparam logic [2:0] S0 = 3'd0;  // ALLRED_A
    localparam logic [2:0] S1 = 3'd1;  // HWY_G
    localparam logic [2:0] S2 = 3'd2;  // HWY_Y
    localparam logic [2:0] S3 = 3'd3;  // ALLRED_B
    localparam logic [2:0] S4 = 3'd4;  // FARM_G
    localparam logic [2:0] S5 = 3'd5;  // FARM_Y

    localparam logic [1:0] GREEN  = 2'b11;
    localparam logic [1:0] YELLOW = 2'b10;
    localparam logic [1:0] RED    = 2'b00;

    localparam int unsigned SEC1  = 32'd50_000_000;
    localparam int unsigned SEC3  = 32'd150_000_000;
    localparam int unsigned SEC15 = 32'd750_000_000;
    localparam int unsigned SEC30 = 32'd1_500_000_000;

endpackage

// File: rtl/tlc_param_check.sv
// Simulation-time legality check of the scheduler timing parameters.
module tlc_param_check #(
    parameter int unsigned ALLRED_CYC   = 1,
    parameter int unsigned YEL_CYC      = 1,
    parameter int unsigned HWY_MIN_CYC  = 1,
    parameter int unsigned FARM_MIN_CYC = 1,
    parameter int unsigned FARM_MAX_CYC = 1
) (
    input logic Clk
);

    // Every parameter nonzero and the farm min not above the farm max.
    always @(posedge Clk) begin
        assert ((ALLRED_CYC >= 32'd1) && (YEL_CYC >= 32'd1) && (HWY_MIN_CYC >= 32'd1) &&
                (FARM_MIN_CYC >= 32'd1) && (FARM_MAX_CYC >= 32'd1) &&
                (FARM_MIN_CYC <= FARM_MAX_CYC))
        else $error("tlc_phase_scheduler: illegal timing parameters");
    end

endmodule

// File: rtl/tlc_phase_timer.sv
// Per-phase cycle counter: clears on request, otherwise counts up, optionally
// holding at a saturation value instead of wrapping.
module tlc_phase_timer #(
    parameter int unsigned CW = 31
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          clr_i,
    input  logic          sat_en_i,
    input  logic [CW-1:0] sat_val_i,
    output logic [CW-1:0] count_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear beats saturate beats increment.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (sat_en_i && (count_q >= sat_val_i)) begin
            count_d = sat_val_i;
        end else begin
            count_d = count_q + CW'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/tlc_phase_scheduler.sv
// Sensor-driven highway/farm-road phase sequencer with Moore lamp decode.
// Optional pedestrian walk support is enabled by defining TLC_PED_WALK_EN.
module tlc_phase_scheduler
    import tlc_pkg::*;
#(
    parameter int unsigned ALLRED_CYC   = SEC1,
    parameter int unsigned YEL_CYC      = SEC3,
    parameter int unsigned HWY_MIN_CYC  = SEC30,
    parameter int unsigned FARM_MIN_CYC = SEC3,
    parameter int unsigned FARM_MAX_CYC = SEC15,
    parameter int unsigned CW           = 31
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          FarmSensor,
    input  logic          PedReq,
    output logic [1:0]    highwaySignal,
    output logic [1:0]    farmSignal,
    output logic          Walk,
    output logic          ReqPending,
    output logic [2:0]    state,
    output logic [CW-1:0] Count
);

`ifdef TLC_PED_WALK_EN
    localparam logic PED_EN = 1'b1;
`else
    localparam logic PED_EN = 1'b0;
`endif

    localparam logic [CW-1:0] ALLRED_LAST = CW'(ALLRED_CYC - 32'd1);
    localparam logic [CW-1:0] YEL_LAST    = CW'(YEL_CYC - 32'd1);
    localparam logic [CW-1:0] HWY_LAST    = CW'(HWY_MIN_CYC - 32'd1);
    localparam logic [CW-1:0] FMIN_LAST   = CW'(FARM_MIN_CYC - 32'd1);
    localparam logic [CW-1:0] FMAX_LAST   = CW'(FARM_MAX_CYC - 32'd1);

    logic [2:0]    state_q;
    logic [2:0]    state_d;
    logic          req_q;
    logic          req_d;
    logic [CW-1:0] count_s;
    logic          req_src_s;
    logic          s4_entry_s;

    // A pedestrian press shares the min-green guarantee already given to a
    // farm request, so the walk option only widens the request source.
    assign req_src_s  = FarmSensor | (PedReq & PED_EN);
    assign s4_entry_s = (state_d == S4) && (state_q != S4);

    tlc_phase_timer #(
        .CW (CW)
    ) u_timer (
        .Clk       (Clk),
        .Rst       (Rst),
        .clr_i     (state_d != state_q),
        .sat_en_i  (state_q == S1),
        .sat_val_i (HWY_LAST),
        .count_o   (count_s)
    );

    tlc_param_check #(
        .ALLRED_CYC   (ALLRED_CYC),
        .YEL_CYC      (YEL_CYC),
        .HWY_MIN_CYC  (HWY_MIN_CYC),
        .FARM_MIN_CYC (FARM_MIN_CYC),
        .FARM_MAX_CYC (FARM_MAX_CYC)
    ) u_param_check (
        .Clk (Clk)
    );

    // Phase transition decision.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S0: if (count_s == ALLRED_LAST) state_d = S1; else state_d = S0;
            S1: if ((count_s >= HWY_LAST) && req_q) state_d = S2; else state_d = S1;
            S2: if (count_s == YEL_LAST) state_d = S3; else state_d = S2;
            S3: if (count_s == ALLRED_LAST) state_d = S4; else state_d = S3;
            S4: begin
                // The max cap ends farm green even with the sensor still high.
                if (((count_s >= FMIN_LAST) && !FarmSensor) || (count_s == FMAX_LAST)) begin
                    state_d = S5;
                end else begin
                    state_d = S4;
                end
            end
            S5: if (count_s == YEL_LAST) state_d = S0; else state_d = S5;
            default: state_d = S0;
        endcase
    end

    // Request latch: clear on farm-green entry wins over a coincident set.
    always_comb begin
        req_d = req_q;
        if (s4_entry_s) begin
            req_d = 1'b0;
        end else if (req_src_s && (state_q != S4)) begin
            req_d = 1'b1;
        end else begin
            req_d = req_q;
        end
    end

    // Phase and request registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
        end
    end

    // Moore lamp decode from the registered phase.
    always_comb begin
        highwaySignal = RED;
        farmSignal    = RED;
        case (state_q)
            S1:      highwaySignal = GREEN;
            S2:      highwaySignal = YELLOW;
            S4:      farmSignal    = GREEN;
            S5:      farmSignal    = YELLOW;
            default: begin
                highwaySignal = RED;
                farmSignal    = RED;
            end
        endcase
    end

    assign Walk       = PED_EN & (state_q == S4);
    assign ReqPending = req_q;
    assign state      = state_q;
    assign Count      = count_s;

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Directed plus randomized bench for tlc_phase_scheduler against a phase-duration
// reference model; honours TLC_PED_WALK_EN when defined.
module tb_tlc_phase_scheduler;

    localparam int AR   = 2;
    localparam int YL   = 3;
    localparam int HM   = 8;
    localparam int FMIN = 3;
    localparam int FMAX = 6;

`ifdef TLC_PED_WALK_EN
    localparam bit PED = 1'b1;
`else
    localparam bit PED = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Rst;
    logic        FarmSensor;
    logic        PedReq;
    logic [1:0]  hwy;
    logic [1:0]  farm;
    logic        Walk;
    logic        ReqPending;
    logic [2:0]  state;
    logic [30:0] Count;

    int checks = 0;
    int errors = 0;

    // Reference: current phase, cycles already spent in it, latched request.
    int m_ph  = 0;
    int m_cnt = 0;
    bit m_req = 1'b0;

    tlc_phase_scheduler #(
        .ALLRED_CYC   (AR),
        .YEL_CYC      (YL),
        .HWY_MIN_CYC  (HM),
        .FARM_MIN_CYC (FMIN),
        .FARM_MAX_CYC (FMAX),
        .CW           (31)
    ) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .FarmSensor    (FarmSensor),
        .PedReq        (PedReq),
        .highwaySignal (hwy),
        .farmSignal    (farm),
        .Walk          (Walk),
        .ReqPending    (ReqPending),
        .state         (state),
        .Count         (Count)
    );

    always #5 Clk = ~Clk;

    function automatic int len_of(int ph);
        case (ph)
            0, 3:    return AR;
            2, 5:    return YL;
            1:       return HM;
            4:       return FMAX;
            default: return 1;
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock: predict from the rules, then compare every output.
    task automatic tick();
        int nph;
        int ncnt;
        bit nreq;
        bit leave;
        int el;
        if (Rst) begin
            nph = 0; ncnt = 0; nreq = 1'b0;
        end else begin
            el = m_cnt + 1;
            case (m_ph)
                1:       leave = (el >= HM) && m_req;
                4:       leave = ((el >= FMIN) && !FarmSensor) || (el == FMAX);
                default: leave = (el == len_of(m_ph));
            endcase
            nph  = leave ? (m_ph + 1) % 6 : m_ph;
            ncnt = leave ? 0 : ((m_ph == 1 && el > HM - 1) ? HM - 1 : el);
            if (nph == 4 && m_ph != 4) nreq = 1'b0;
            else nreq = m_req | ((FarmSensor | (PedReq & PED)) && (m_ph != 4));
        end
        @(posedge Clk);
        m_ph = nph; m_cnt = ncnt; m_req = nreq;
        #1;
        check("state", 32'(state), 32'(m_ph));
        check("count", 32'(Count), 32'(m_cnt));
        check("hwy_lamp", 32'(hwy), (m_ph == 1) ? 32'd3 : (m_ph == 2) ? 32'd2 : 32'd0);
        check("farm_lamp", 32'(farm), (m_ph == 4) ? 32'd3 : (m_ph == 5) ? 32'd2 : 32'd0);
        check("req_pending", 32'(ReqPending), 32'(m_req));
        check("walk", 32'(Walk), 32'(PED && m_ph == 4));
    endtask

    task automatic wait_for(int tgt, int budget, string tag);
        int n = 0;
        while (state !== 3'(tgt) && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(state), 32'(tgt));
    endtask

    // Count cycles spent in the current phase from its entry cycle onward.
    task automatic measure(int tgt, int start_len, output int len);
        len = start_len;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (state === 3'(tgt)) len++;
            else break;
        end
    endtask

    initial begin
        int len;
        int walk_n;

        Rst = 1'b1; FarmSensor = 1'b0; PedReq = 1'b0;
        tick(); tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_lamps", 32'({hwy, farm}), 32'd0);
        Rst = 1'b0;

        // Idle highway: two all-red cycles then an indefinitely held green.
        tick(); tick();
        check("s1_entry", 32'(state), 32'd1);
        repeat (50) tick();
        check("s1_hold", 32'(state), 32'd1);
        check("s1_sat_count", 32'(Count), 32'(HM - 1));

        FarmSensor = 1'b1; tick(); FarmSensor = 1'b0;
        wait_for(4, 30, "reach_s4_a");
        check("req_clr_s4", 32'(ReqPending), 32'd0);

        // Sensor stuck high: max cap, then the request re-latches in yellow.
        FarmSensor = 1'b1;
        measure(4, 1, len);
        check("s4_cap_len", 32'(len), 32'(FMAX));
        wait_for(0, 10, "reach_s0_b");
        check("req_reset_s5", 32'(ReqPending), 32'd1);
        FarmSensor = 1'b0;
        wait_for(1, 10, "reach_s1_b");
        measure(1, 1, len);
        check("s1_req_len", 32'(len), 32'(HM));

        // Sensor drops early: farm green still runs its minimum.
        wait_for(4, 10, "reach_s4_c");
        FarmSensor = 1'b1; tick(); FarmSensor = 1'b0;
        measure(4, 2, len);
        check("s4_min_len", 32'(len), 32'(FMIN));

        // One-cycle pulse at Count=2 of a fresh highway green.
        wait_for(1, 20, "reach_s1_d");
        tick(); tick();
        FarmSensor = 1'b1; tick(); FarmSensor = 1'b0;
        measure(1, 4, len);
        check("s1_pulse_len", 32'(len), 32'(HM));

        // Reset in the middle of farm green.
        wait_for(4, 10, "reach_s4_e");
        tick(); tick();
        Rst = 1'b1; tick(); Rst = 1'b0;
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_count", 32'(Count), 32'd0);
        check("midrst_req", 32'(ReqPending), 32'd0);

`ifdef TLC_PED_WALK_EN
        wait_for(1, 10, "ped_s1");
        PedReq = 1'b1; tick(); PedReq = 1'b0;
        wait_for(4, 30, "ped_s4");
        walk_n = 0;
        for (int i = 0; i < 30; i++) begin
            if (state === 3'd0) break;
            if (Walk === 1'b1) walk_n++;
            tick();
        end
        check("walk_len", 32'(walk_n), 32'(FMIN));
`else
        walk_n = 0;
        for (int i = 0; i < 30; i++) begin
            if (Walk !== 1'b0) walk_n++;
            PedReq = i[0];
            tick();
        end
        PedReq = 1'b0;
        check("walk_off", 32'(walk_n), 32'd0);
`endif

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) FarmSensor = ~FarmSensor;
            PedReq = ($urandom_range(0, 15) == 0);
            Rst    = ($urandom_range(0, 99) == 0);
            tick();
        end
        Rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
